// File: rtl/bus_sram_slave.sv
// Bus target serving single and burst reads/writes out of a private 512x32 SRAM.
// Reads pass through a two-slot output/skid stage so master stalls never bubble or repeat.
module bus_sram_slave #(
  parameter logic [31:0] baseAddress = 32'h5000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic        endTransactionIn,
  input  logic        readNotWriteIn,
  input  logic        dataValidIn,
  input  logic        busyIn,
  input  logic [31:0] addressDataIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  output logic        endTransactionOut,
  output logic        dataValidOut,
  output logic        busErrorOut,
  output logic        busyOut,
  output logic [31:0] addressDataOut
);

  // state    | meaning
  // IDLE     | waiting for a begin that hits the window
  // WRITE    | accepting write data words
  // READ     | fetching from SRAM and presenting read words
  // READ_END | endTransactionOut pulse
  // ERROR    | busErrorOut pulse
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WRITE    = 3'd1;
  localparam logic [2:0] READ     = 3'd2;
  localparam logic [2:0] READ_END = 3'd3;
  localparam logic [2:0] ERROR    = 3'd4;

  logic [2:0]  state;
  logic [8:0]  wordAddr;
  logic [8:0]  countLeft;
  logic [8:0]  sendLeft;
  logic [3:0]  byteEnables;
  logic [31:0] mem [0:511];
  logic [31:0] memQ;
  logic [31:0] outData;
  logic [31:0] skidData;
  logic        memQValid;
  logic        outValid;
  logic        skidValid;

  logic        hit;
  logic        badRequest;
  logic        goodRead;
  logic        transfer;
  logic        fetch;
  logic        memRead;
  logic        memWrite;
  logic [8:0]  startWord;
  logic [8:0]  memAddr;
  logic [9:0]  lastWord;
  logic [1:0]  heldNext;

  always_comb begin
    startWord  = addressDataIn[10:2];
    lastWord   = {1'b0, startWord} + {2'b00, burstSizeIn};
    hit        = beginTransactionIn && (addressDataIn[31:11] == baseAddress[31:11]);
    badRequest = (addressDataIn[1:0] != 2'b00) || (lastWord > 10'd511);
    goodRead   = (state == IDLE) && hit && !badRequest && readNotWriteIn;
    transfer   = outValid && !busyIn;
    // Words that will still sit in out/skid after this cycle, counting the one arriving from SRAM.
    heldNext   = {1'b0, outValid} + {1'b0, skidValid} + {1'b0, memQValid} - {1'b0, transfer};
    fetch      = (state == READ) && !endTransactionIn && (countLeft != 9'd0) && (heldNext < 2'd2);
    memRead    = goodRead || fetch;
    memWrite   = (state == WRITE) && dataValidIn && (countLeft != 9'd0) && !reset;
    memAddr    = (state == IDLE) ? startWord : wordAddr;
  end

  always_ff @(posedge clock) begin
    if (memWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEnables[b]) mem[memAddr][8*b +: 8] <= addressDataIn[8*b +: 8];
      end
    end
    if (memRead) memQ <= mem[memAddr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wordAddr    <= 9'd0;
      countLeft   <= 9'd0;
      sendLeft    <= 9'd0;
      byteEnables <= 4'd0;
      memQValid   <= 1'b0;
      outValid    <= 1'b0;
      skidValid   <= 1'b0;
      outData     <= 32'd0;
      skidData    <= 32'd0;
    end else begin
      memQValid <= memRead;
      case (state)
        IDLE: begin
          outValid  <= 1'b0;
          skidValid <= 1'b0;
          if (hit) begin
            byteEnables <= byteEnablesIn;
            if (badRequest) begin
              state <= ERROR;
            end else if (readNotWriteIn) begin
              // First word is fetched in the begin cycle to meet the two-cycle read latency.
              state     <= READ;
              wordAddr  <= startWord + 9'd1;
              countLeft <= {1'b0, burstSizeIn};
              sendLeft  <= {1'b0, burstSizeIn} + 9'd1;
            end else begin
              state     <= WRITE;
              wordAddr  <= startWord;
              countLeft <= {1'b0, burstSizeIn} + 9'd1;
            end
          end
        end
        WRITE: begin
          if (memWrite) begin
            wordAddr  <= wordAddr + 9'd1;
            countLeft <= countLeft - 9'd1;
          end
          if (endTransactionIn) state <= IDLE;
        end
        READ: begin
          if (endTransactionIn) begin
            state     <= IDLE;
            outValid  <= 1'b0;
            skidValid <= 1'b0;
          end else begin
            if (fetch) begin
              wordAddr  <= wordAddr + 9'd1;
              countLeft <= countLeft - 9'd1;
            end
            if (!outValid || transfer) begin
              if (skidValid) begin
                outData   <= skidData;
                skidValid <= memQValid;
                skidData  <= memQ;
              end else begin
                outValid <= memQValid;
                outData  <= memQ;
              end
            end else if (memQValid) begin
              skidValid <= 1'b1;
              skidData  <= memQ;
            end
            if (transfer) begin
              sendLeft <= sendLeft - 9'd1;
              if (sendLeft == 9'd1) begin
                state    <= READ_END;
                outValid <= 1'b0;
              end
            end
          end
        end
        READ_END: begin
          outValid  <= 1'b0;
          skidValid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign endTransactionOut = (state == READ_END);
  assign busErrorOut       = (state == ERROR);
  assign dataValidOut      = outValid;
  assign busyOut           = 1'b0;
  assign addressDataOut    = outValid ? outData : 32'd0;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Self-checking bench for bus_sram_slave against a word-array memory model.
module tb_bus_sram_slave;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        beginTransactionIn = 1'b0;
  logic        endTransactionIn = 1'b0;
  logic        readNotWriteIn = 1'b0;
  logic        dataValidIn = 1'b0;
  logic        busyIn = 1'b0;
  logic [31:0] addressDataIn = 32'd0;
  logic [3:0]  byteEnablesIn = 4'd0;
  logic [7:0]  burstSizeIn = 8'd0;
  logic        endTransactionOut;
  logic        dataValidOut;
  logic        busErrorOut;
  logic        busyOut;
  logic [31:0] addressDataOut;

  bus_sram_slave #(.baseAddress(BASE)) dut (
    .clock(clock), .reset(reset),
    .beginTransactionIn(beginTransactionIn), .endTransactionIn(endTransactionIn),
    .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn), .busyIn(busyIn),
    .addressDataIn(addressDataIn), .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn),
    .endTransactionOut(endTransactionOut), .dataValidOut(dataValidOut),
    .busErrorOut(busErrorOut), .busyOut(busyOut), .addressDataOut(addressDataOut)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [31:0] refMem [0:511];
  logic [31:0] wrData [$];
  logic [31:0] rdWords [$];
  int rdFirst, rdEnd, rdStalls, rdBubbles, rdHoldErr;
  int writeNoise = 0;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = oldW;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = newW[8*b +: 8];
    return r;
  endfunction

  function automatic logic anyOutput();
    return endTransactionOut | dataValidOut | busErrorOut | busyOut | (addressDataOut != 32'd0);
  endfunction

  task automatic idleIn();
    beginTransactionIn = 1'b0; endTransactionIn = 1'b0; readNotWriteIn = 1'b0;
    dataValidIn = 1'b0; busyIn = 1'b0; addressDataIn = 32'd0;
    byteEnablesIn = 4'd0; burstSizeIn = 8'd0;
  endtask

  task automatic tick();
    @(negedge clock);
    idleIn();
  endtask

  task automatic startTx(input logic [31:0] addr, input logic rnw, input int burst, input logic [3:0] be);
    tick();
    beginTransactionIn = 1'b1; addressDataIn = addr; readNotWriteIn = rnw;
    burstSizeIn = 8'(burst); byteEnablesIn = be;
  endtask

  // Sends every word of wrData; only the first burst+1 reach the model.
  task automatic doWrite(input int start, input int burst, input logic [3:0] be,
                         input bit gaps, input bit endWithLast);
    int sent;
    sent = 0;
    startTx(BASE + 32'(start) * 4, 1'b0, burst, be);
    while (sent < wrData.size()) begin
      tick();
      if (anyOutput()) writeNoise++;
      if (gaps && $urandom_range(0, 2) == 0) continue;
      dataValidIn = 1'b1;
      addressDataIn = wrData[sent];
      if (sent <= burst) refMem[start + sent] = mergeBytes(refMem[start + sent], wrData[sent], be);
      sent++;
      if (sent == wrData.size() && endWithLast) endTransactionIn = 1'b1;
    end
    if (!endWithLast) begin
      tick();
      if (anyOutput()) writeNoise++;
      endTransactionIn = 1'b1;
    end
  endtask

  // stallMode: 0 none, 1 random busy, 2 busy for two cycles while the second word is shown.
  task automatic doRead(input int start, input int burst, input int stallMode);
    logic        prevHeld;
    logic [31:0] prevData;
    int transfers, directedStalls;
    rdWords.delete();
    rdFirst = -1; rdEnd = -1; rdStalls = 0; rdBubbles = 0; rdHoldErr = 0;
    prevHeld = 1'b0; prevData = 32'd0; transfers = 0; directedStalls = 0;
    startTx(BASE + 32'(start) * 4, 1'b1, burst, 4'($urandom));
    for (int c = 1; c < 700; c++) begin
      tick();
      if (endTransactionOut) begin
        rdEnd = c;
        break;
      end
      if (dataValidOut) begin
        if (rdFirst < 0) rdFirst = c;
        if (prevHeld && addressDataOut !== prevData) rdHoldErr++;
        if (stallMode == 1) busyIn = ($urandom_range(0, 3) == 0);
        else if (stallMode == 2 && transfers == 1 && directedStalls < 2) begin
          busyIn = 1'b1;
          directedStalls++;
        end
        if (busyIn) rdStalls++;
        prevHeld = busyIn;
        prevData = addressDataOut;
        if (!busyIn) begin
          rdWords.push_back(addressDataOut);
          transfers++;
        end
      end else begin
        if (rdFirst >= 0 && transfers < burst + 1) rdBubbles++;
        prevHeld = 1'b0;
        if (stallMode == 1) busyIn = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (anyOutput() !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got et=%b dv=%b err=%b busy=%b data=%h, expected all 0",
               endTransactionOut, dataValidOut, busErrorOut, busyOut, addressDataOut);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (anyOutput() !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: outputs active, expected all 0");
    end
  endtask

  task automatic test_fill();
    for (int h = 0; h < 2; h++) begin
      wrData.delete();
      for (int i = 0; i < 256; i++) wrData.push_back($urandom);
      doWrite(h * 256, 255, 4'hF, 1'b0, 1'b0);
    end
    doRead(0, 255, 1);
    checks++;
    if (rdWords.size() != 256) begin
      failures++;
      $display("FAIL fill_count: got %0d words, expected 256", rdWords.size());
    end
    for (int i = 0; i < rdWords.size(); i++) begin
      checks++;
      if (rdWords[i] !== refMem[i]) begin
        failures++;
        $display("FAIL fill_word[%0d]: got %h expected %h", i, rdWords[i], refMem[i]);
      end
    end
    checks++;
    if (rdEnd != 2 + 256 + rdStalls) begin
      failures++;
      $display("FAIL fill_end: got cycle %0d expected %0d", rdEnd, 2 + 256 + rdStalls);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] expW [4];
    expW[0] = 32'h11; expW[1] = 32'h22; expW[2] = 32'h33; expW[3] = 32'h44;
    wrData.delete();
    for (int i = 0; i < 4; i++) wrData.push_back(expW[i]);
    doWrite(4, 3, 4'hF, 1'b0, 1'b0);
    doRead(4, 3, 0);
    checks++;
    if (rdFirst != 2 || rdEnd != 6) begin
      failures++;
      $display("FAIL wr_rd_timing: got first=%0d end=%0d expected first=2 end=6", rdFirst, rdEnd);
    end
    checks++;
    if (rdWords.size() != 4) begin
      failures++;
      $display("FAIL wr_rd_count: got %0d expected 4", rdWords.size());
    end
    for (int i = 0; i < rdWords.size() && i < 4; i++) begin
      checks++;
      if (rdWords[i] !== expW[i]) begin
        failures++;
        $display("FAIL wr_rd_word[%0d]: got %h expected %h", i, rdWords[i], expW[i]);
      end
    end
  endtask

  task automatic test_partial_write();
    wrData.delete(); wrData.push_back(32'h11223344);
    doWrite(20, 0, 4'hF, 1'b0, 1'b0);
    wrData.delete(); wrData.push_back(32'hAABBCCDD);
    doWrite(20, 0, 4'h3, 1'b0, 1'b0);
    doRead(20, 0, 0);
    checks++;
    if (rdWords.size() != 1 || rdWords[0] !== 32'h1122CCDD) begin
      failures++;
      $display("FAIL partial_write: got %h (n=%0d) expected 1122ccdd",
               rdWords.size() > 0 ? rdWords[0] : 32'd0, rdWords.size());
    end
  endtask

  task automatic test_read_stall();
    doRead(4, 3, 2);
    checks++;
    if (rdEnd != 8 || rdStalls != 2) begin
      failures++;
      $display("FAIL stall_timing: got end=%0d stalls=%0d expected end=8 stalls=2", rdEnd, rdStalls);
    end
    checks++;
    if (rdHoldErr != 0 || rdBubbles != 0) begin
      failures++;
      $display("FAIL stall_hold: got holdErr=%0d bubbles=%0d expected 0 0", rdHoldErr, rdBubbles);
    end
    checks++;
    if (rdWords.size() != 4) begin
      failures++;
      $display("FAIL stall_count: got %0d expected 4", rdWords.size());
    end
    for (int i = 0; i < rdWords.size() && i < 4; i++) begin
      checks++;
      if (rdWords[i] !== 32'(8'h11 * (i + 1))) begin
        failures++;
        $display("FAIL stall_word[%0d]: got %h expected %h", i, rdWords[i], 32'(8'h11 * (i + 1)));
      end
    end
  endtask

  task automatic test_miss_error();
    int activity;
    activity = 0;
    startTx(BASE + 32'h800, 1'b1, 3, 4'hF);
    repeat (6) begin
      tick();
      if (anyOutput()) activity++;
    end
    startTx(BASE + 32'h800, 1'b0, 0, 4'hF);
    tick(); if (anyOutput()) activity++;
    dataValidIn = 1'b1; addressDataIn = ~refMem[0];
    tick(); if (anyOutput()) activity++;
    endTransactionIn = 1'b1;
    tick(); if (anyOutput()) activity++;
    checks++;
    if (activity != 0) begin
      failures++;
      $display("FAIL miss_quiet: got %0d active cycles expected 0", activity);
    end
    doRead(0, 0, 0);
    checks++;
    if (rdWords.size() != 1 || rdWords[0] !== refMem[0]) begin
      failures++;
      $display("FAIL miss_no_write: got %h expected %h", rdWords.size() > 0 ? rdWords[0] : 32'd0, refMem[0]);
    end

    startTx(BASE + 32'h7F8, 1'b0, 2, 4'hF);
    tick();
    checks++;
    if (busErrorOut !== 1'b1 || dataValidOut !== 1'b0) begin
      failures++;
      $display("FAIL range_error_t1: got err=%b dv=%b expected err=1 dv=0", busErrorOut, dataValidOut);
    end
    dataValidIn = 1'b1; addressDataIn = ~refMem[510];
    tick();
    checks++;
    if (busErrorOut !== 1'b0) begin
      failures++;
      $display("FAIL range_error_t2: got err=%b expected 0", busErrorOut);
    end
    doRead(510, 1, 0);
    checks++;
    if (rdWords.size() != 2 || rdWords[0] !== refMem[510] || rdWords[1] !== refMem[511] || rdEnd != 4) begin
      failures++;
      $display("FAIL range_top_read: got n=%0d w0=%h end=%0d expected n=2 w0=%h end=4",
               rdWords.size(), rdWords.size() > 0 ? rdWords[0] : 32'd0, rdEnd, refMem[510]);
    end

    startTx(BASE + 32'h2, 1'b1, 0, 4'hF);
    tick();
    checks++;
    if (busErrorOut !== 1'b1 || dataValidOut !== 1'b0) begin
      failures++;
      $display("FAIL misalign_t1: got err=%b dv=%b expected err=1 dv=0", busErrorOut, dataValidOut);
    end
    tick();
    checks++;
    if (anyOutput() !== 1'b0) begin
      failures++;
      $display("FAIL misalign_t2: got err=%b dv=%b expected all 0", busErrorOut, dataValidOut);
    end
  endtask

  task automatic test_abort();
    int seen, activity;
    seen = 0; activity = 0;
    startTx(BASE + 32'd40 * 4, 1'b1, 3, 4'hF);
    for (int c = 1; c < 20; c++) begin
      tick();
      if (dataValidOut) begin
        seen++;
        if (seen == 2) begin
          endTransactionIn = 1'b1;
          break;
        end
      end
    end
    checks++;
    if (seen != 2) begin
      failures++;
      $display("FAIL abort_reach: got %0d words expected 2", seen);
    end
    tick();
    checks++;
    if (dataValidOut !== 1'b0 || addressDataOut !== 32'd0) begin
      failures++;
      $display("FAIL abort_next: got dv=%b data=%h expected 0 0", dataValidOut, addressDataOut);
    end
    repeat (3) begin
      tick();
      if (anyOutput()) activity++;
    end
    checks++;
    if (activity != 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", activity);
    end
    doRead(40, 0, 0);
    checks++;
    if (rdWords.size() != 1 || rdWords[0] !== refMem[40]) begin
      failures++;
      $display("FAIL abort_recover: got %h expected %h", rdWords.size() > 0 ? rdWords[0] : 32'd0, refMem[40]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    startTx(BASE + 32'd100 * 4, 1'b0, 7, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      d = $urandom;
      dataValidIn = 1'b1; addressDataIn = d;
      refMem[100 + i] = d;
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (anyOutput() !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: outputs active after reset, expected all 0");
    end
    dataValidIn = 1'b1; addressDataIn = $urandom;
    repeat (2) begin
      tick();
      dataValidIn = 1'b1; addressDataIn = $urandom;
    end
    doRead(100, 7, 0);
    checks++;
    if (rdWords.size() != 8) begin
      failures++;
      $display("FAIL reset_mid_count: got %0d expected 8", rdWords.size());
    end
    for (int i = 0; i < rdWords.size() && i < 8; i++) begin
      checks++;
      if (rdWords[i] !== refMem[100 + i]) begin
        failures++;
        $display("FAIL reset_mid_word[%0d]: got %h expected %h", i, rdWords[i], refMem[100 + i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    wrData.delete(); wrData.push_back($urandom); wrData.push_back($urandom);
    doWrite(300, 1, 4'hF, 1'b0, 1'b1);
    doRead(300, 1, 0);
    checks++;
    if (rdEnd != 4 || rdWords.size() != 2 || rdWords[0] !== refMem[300] || rdWords[1] !== refMem[301]) begin
      failures++;
      $display("FAIL b2b_read1: got end=%0d n=%0d expected end=4 n=2 w0=%h", rdEnd, rdWords.size(), refMem[300]);
    end
    doRead(302, 2, 0);
    checks++;
    if (rdEnd != 5 || rdWords.size() != 3 || rdWords[2] !== refMem[304]) begin
      failures++;
      $display("FAIL b2b_read2: got end=%0d n=%0d expected end=5 n=3 w2=%h", rdEnd, rdWords.size(), refMem[304]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int start, burst, maxB, extra;
      logic [3:0] be;
      start = (it % 5 == 0) ? 511 - int'($urandom_range(0, 3)) : int'($urandom_range(0, 511));
      maxB = 511 - start;
      if (maxB > 15) maxB = 15;
      burst = $urandom_range(0, maxB);
      be = 4'($urandom_range(1, 15));
      extra = $urandom_range(0, 2);
      wrData.delete();
      for (int i = 0; i < burst + 1 + extra; i++) wrData.push_back($urandom);
      doWrite(start, burst, be, 1'b1, ($urandom_range(0, 1) == 1));
      doRead(start, burst, 1);
      checks++;
      if (rdFirst != 2 || rdEnd != 2 + burst + 1 + rdStalls || rdBubbles != 0 || rdHoldErr != 0) begin
        failures++;
        $display("FAIL rand_timing[%0d]: got first=%0d end=%0d bub=%0d hold=%0d expected 2 %0d 0 0",
                 it, rdFirst, rdEnd, rdBubbles, rdHoldErr, 2 + burst + 1 + rdStalls);
      end
      checks++;
      if (rdWords.size() != burst + 1) begin
        failures++;
        $display("FAIL rand_count[%0d]: got %0d expected %0d", it, rdWords.size(), burst + 1);
      end
      for (int i = 0; i < rdWords.size() && i <= burst; i++) begin
        checks++;
        if (rdWords[i] !== refMem[start + i]) begin
          failures++;
          $display("FAIL rand_word[%0d.%0d]: got %h expected %h", it, i, rdWords[i], refMem[start + i]);
        end
      end
    end
    checks++;
    if (writeNoise != 0) begin
      failures++;
      $display("FAIL write_quiet: got %0d active cycles during writes expected 0", writeNoise);
    end
  endtask

  initial begin
    idleIn();
    test_reset();
    test_fill();
    test_write_read();
    test_partial_write();
    test_read_stall();
    test_miss_error();
    test_abort();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
